// File: rtl/dadda_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one external 3-row Dadda compressor
// and a single final carry-propagate add among NumReq requesters.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (ready is one-hot or zero)
//   req_sum0/1/2             packed per-requester rows, weights x1, x4, x16
//   dadda_sum0/1/2           registered rows driven into the shared compressor
//   dadda_vector0/1          compressor carry/sum vectors (combinational return)
//   rsp_valid/rsp_ready      response handshake
//   rsp_id, rsp_result, rsp_ovf  served requester, final sum, carry out
module dadda_share_arbiter #(
  parameter int unsigned InputWidth  = 8,
  parameter int unsigned OutputWidth = 12,
  parameter int unsigned NumReq      = 4,
  parameter int unsigned IdWidth     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NumReq-1:0]            req_valid,
  output logic [NumReq-1:0]            req_ready,
  input  logic [NumReq*InputWidth-1:0] req_sum0,
  input  logic [NumReq*InputWidth-1:0] req_sum1,
  input  logic [NumReq*InputWidth-1:0] req_sum2,
  output logic [InputWidth-1:0]        dadda_sum0,
  output logic [InputWidth-1:0]        dadda_sum1,
  output logic [InputWidth-1:0]        dadda_sum2,
  input  logic [OutputWidth-1:0]       dadda_vector0,
  input  logic [OutputWidth-1:0]       dadda_vector1,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [IdWidth-1:0]           rsp_id,
  output logic [OutputWidth-1:0]       rsp_result,
  output logic                         rsp_ovf
);

  typedef enum logic [1:0] {IDLE, ISSUE, ADD, RESP} state_e;

  state_e                 state_q, state_d;
  logic [IdWidth-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdWidth-1:0]     grant_id_q, grant_id_d;
  logic [InputWidth-1:0]  sum0_q, sum0_d, sum1_q, sum1_d, sum2_q, sum2_d;
  logic [OutputWidth-1:0] vec0_q, vec0_d, vec1_q, vec1_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [IdWidth-1:0]     rsp_id_q, rsp_id_d;
  logic [OutputWidth-1:0] rsp_result_q, rsp_result_d;
  logic                   rsp_ovf_q, rsp_ovf_d;

  logic                   found;
  int unsigned            win_idx;
  int unsigned            cand;
  logic [InputWidth-1:0]  win_sum0, win_sum1, win_sum2;
  logic [OutputWidth:0]   sum_full;

  // Rotating search starting at rr_ptr; first valid requester wins.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    cand    = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = (32'(rr_ptr_q) + k) % NumReq;
      if (!found && req_valid[cand[IdWidth-1:0]]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_sum0 = InputWidth'(req_sum0 >> (win_idx * InputWidth));
  assign win_sum1 = InputWidth'(req_sum1 >> (win_idx * InputWidth));
  assign win_sum2 = InputWidth'(req_sum2 >> (win_idx * InputWidth));

  assign sum_full = {1'b0, vec0_q} + {1'b0, vec1_q};

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    sum0_d       = sum0_q;
    sum1_d       = sum1_q;
    sum2_d       = sum2_q;
    vec0_d       = vec0_q;
    vec1_d       = vec1_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    req_ready    = '0;
    unique case (state_q)
      IDLE: begin
        // Ready is only raised for a valid winner, so found == handshake.
        if (found) begin
          req_ready  = NumReq'(1) << win_idx;
          sum0_d     = win_sum0;
          sum1_d     = win_sum1;
          sum2_d     = win_sum2;
          grant_id_d = IdWidth'(win_idx);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        vec0_d  = dadda_vector0;
        vec1_d  = dadda_vector1;
        state_d = ADD;
      end
      ADD: begin
        {rsp_ovf_d, rsp_result_d} = sum_full;
        rsp_id_d    = grant_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = IdWidth'((32'(grant_id_q) + 32'd1) % NumReq);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      sum0_q       <= '0;
      sum1_q       <= '0;
      sum2_q       <= '0;
      vec0_q       <= '0;
      vec1_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      sum0_q       <= sum0_d;
      sum1_q       <= sum1_d;
      sum2_q       <= sum2_d;
      vec0_q       <= vec0_d;
      vec1_q       <= vec1_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  assign dadda_sum0 = sum0_q;
  assign dadda_sum1 = sum1_q;
  assign dadda_sum2 = sum2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_ovf    = rsp_ovf_q;

endmodule
